// File: rtl/bus_nxm_pkg.sv
// Shared types and helpers for the N-master / M-slave bus.
// Pure combinational functions; no state lives here.
// Decode and round-robin search are parametrised through their arguments.
package bus_pkg;

  localparam int DEF_AW = 16;
  localparam int DEF_DW = 32;

  typedef enum logic {ARB_IDLE, ARB_OWN} arb_state_t;

  // Address decode result: hit flag plus slave index (up to 8 slaves).
  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } dec_t;

  // Round-robin search result: found flag plus winning master index.
  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Slave index sits at [sel_lsb +: clog2(num_s)]; the gap between the
  // window and the index field, and everything above the index field,
  // must be zero for the access to land in a window.
  function automatic dec_t addr_decode(input logic [63:0] addr, input int aw,
                                       input int num_s, input int sel_lsb,
                                       input int win_bits);
    dec_t d;
    int   iw;
    int   idx;
    d   = '0;
    d.hit = 1'b1;
    iw  = clog2(num_s);
    idx = 0;
    for (int b = 0; b < 64; b++) begin
      if (b < aw && addr[b]) begin
        if (b >= win_bits && b < sel_lsb) d.hit = 1'b0;
        else if (b >= sel_lsb && b < sel_lsb + iw) idx = idx | (1 << (b - sel_lsb));
        else if (b >= sel_lsb + iw) d.hit = 1'b0;
      end
    end
    if (idx >= num_s) d.hit = 1'b0;
    d.idx = 3'(idx);
    return d;
  endfunction

  // First set request at or after start, walking circularly over n masters.
  function automatic rr_t next_rr(input logic [7:0] req, input int start, input int n);
    rr_t r;
    int  c;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < n && !r.found) begin
        c = (start + i) % n;
        if (req[c]) begin
          r.found = 1'b1;
          r.idx   = 3'(c);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bus_nxm_if.sv
// Master-side and slave-side signal bundle of the shared bus.
// master modport is the bus's view of its masters, slave modport its view of the slaves.
// No logic; all timing is defined by bus_nxm.
interface bus_nxm_if import bus_pkg::*; #(
  parameter int NUM_M = 2,
  parameter int NUM_S = 5,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW
);
  logic [NUM_M-1:0]    m_req;
  logic [NUM_M-1:0]    m_wr;
  logic [NUM_M*AW-1:0] m_addr;
  logic [NUM_M*DW-1:0] m_dout;
  logic [NUM_M-1:0]    m_grant;
  logic [DW-1:0]       m_din;

  logic [NUM_S*DW-1:0] s_dout;
  logic [NUM_S-1:0]    s_sel;
  logic [AW-1:0]       s_addr;
  logic                s_wr;
  logic [DW-1:0]       s_din;
  logic                dec_err;

  modport master (input m_req, m_wr, m_addr, m_dout, output m_grant, m_din);
  modport slave  (input s_dout, output s_sel, s_addr, s_wr, s_din, dec_err);
endinterface

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter with optional grant-hold limit.
// Grant is registered: a request is granted on the following cycle.
// Owner keeps the bus while requesting unless others wait and the hold limit is hit.
module bus_rr_arbiter import bus_pkg::*; #(
  parameter int NUM_M    = 2,
  parameter int MAX_HOLD = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NUM_M-1:0] req,
  output logic [NUM_M-1:0] grant,
  output logic             owned,
  output logic [2:0]       owner
);
  localparam int HCW = 16;

  arb_state_t     state;
  logic [2:0]     rr_ptr;
  logic [HCW-1:0] hold_cnt;
  logic [7:0]     req8;
  logic [7:0]     others;
  rr_t            win_idle;
  rr_t            win_next;
  logic           at_limit;

  assign owned = (state == ARB_OWN);

  // Candidate winners: from rr_ptr when idle, strictly after the owner when handing over.
  always_comb begin
    req8     = 8'(req);
    others   = req8 & ~(8'd1 << owner);
    win_idle = next_rr(req8, int'(rr_ptr), NUM_M);
    win_next = next_rr(others, (int'(owner) + 1) % NUM_M, NUM_M);
    at_limit = (MAX_HOLD != 0) && (hold_cnt == HCW'(MAX_HOLD - 1));
  end

  // Arbiter FSM: IDLE / OWN with registered grant, pointer and hold counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ARB_IDLE;
      grant    <= '0;
      owner    <= '0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (win_idle.found) begin
            state    <= ARB_OWN;
            owner    <= win_idle.idx;
            grant    <= NUM_M'(1) << win_idle.idx;
            rr_ptr   <= 3'((int'(win_idle.idx) + 1) % NUM_M);
            hold_cnt <= '0;
          end
        end
        ARB_OWN: begin
          if (req8[owner] && (others == 8'd0 || !at_limit)) begin
            if (hold_cnt != '1) hold_cnt <= hold_cnt + HCW'(1);
          end else if (win_next.found) begin
            owner    <= win_next.idx;
            grant    <= NUM_M'(1) << win_next.idx;
            rr_ptr   <= 3'((int'(win_next.idx) + 1) % NUM_M);
            hold_cnt <= '0;
          end else begin
            state    <= ARB_IDLE;
            grant    <= '0;
            hold_cnt <= '0;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/bus_nxm.sv
// Shared bus: arbitrates NUM_M masters onto NUM_S slave windows.
// Slave side is combinational from the owner; read data returns one cycle later.
// Masters wait for m_grant; unmapped accesses are dropped and flagged on dec_err.
module bus_nxm import bus_pkg::*; #(
  parameter int NUM_M    = 2,
  parameter int NUM_S    = 5,
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int SEL_LSB  = 8,
  parameter int WIN_BITS = 6,
  parameter int MAX_HOLD = 0
) (
  input  logic       clk,
  input  logic       reset,
  bus_nxm_if.master  mst,
  bus_nxm_if.slave   slv
);
  logic [NUM_M-1:0] grant;
  logic             owned;
  logic [2:0]       owner;
  logic [AW-1:0]    sel_addr;
  logic             sel_wr;
  logic [DW-1:0]    sel_dat;
  dec_t             dec;
  logic             rd_vld;
  logic [2:0]       rd_idx;
  logic             dec_err;

  bus_rr_arbiter #(.NUM_M(NUM_M), .MAX_HOLD(MAX_HOLD)) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (mst.m_req),
    .grant (grant),
    .owned (owned),
    .owner (owner)
  );

  // Owner's signals onto the shared slave bus, zero when nobody owns it.
  always_comb begin
    sel_addr = '0;
    sel_wr   = 1'b0;
    sel_dat  = '0;
    if (owned) begin
      sel_addr = mst.m_addr[owner*AW +: AW];
      sel_wr   = mst.m_wr[owner];
      sel_dat  = mst.m_dout[owner*DW +: DW];
    end
    dec = addr_decode(64'(sel_addr), AW, NUM_S, SEL_LSB, WIN_BITS);
  end

  assign mst.m_grant = grant;
  assign slv.s_addr  = sel_addr;
  assign slv.s_wr    = sel_wr;
  assign slv.s_din   = sel_dat;
  assign slv.s_sel   = (owned && dec.hit) ? (NUM_S'(1) << dec.idx) : '0;
  assign slv.dec_err = dec_err;
  assign mst.m_din   = rd_vld ? slv.s_dout[rd_idx*DW +: DW] : '0;

  // Remember which slave answers next cycle, and flag accesses that missed.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld  <= 1'b0;
      rd_idx  <= '0;
      dec_err <= 1'b0;
    end else begin
      rd_vld  <= owned & ~sel_wr & dec.hit;
      rd_idx  <= dec.idx;
      dec_err <= owned & ~dec.hit;
    end
  end
endmodule

// File: tb/tb_bus_nxm.sv
// Directed bench for bus_nxm: three instances cover the default config,
// a three-master round-robin config and a hold-limited config.
// Outputs are sampled 1 time unit after the falling edge.
module tb_bus_nxm;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  bus_nxm_if #(.NUM_M(2), .NUM_S(5), .AW(16), .DW(32)) ia ();
  bus_nxm_if #(.NUM_M(3), .NUM_S(5), .AW(16), .DW(32)) ib ();
  bus_nxm_if #(.NUM_M(2), .NUM_S(5), .AW(16), .DW(32)) ic ();

  bus_nxm #(.NUM_M(2), .NUM_S(5), .AW(16), .DW(32), .SEL_LSB(8), .WIN_BITS(6), .MAX_HOLD(0))
    dut_a (.clk(clk), .reset(reset), .mst(ia), .slv(ia));
  bus_nxm #(.NUM_M(3), .NUM_S(5), .AW(16), .DW(32), .SEL_LSB(8), .WIN_BITS(6), .MAX_HOLD(0))
    dut_b (.clk(clk), .reset(reset), .mst(ib), .slv(ib));
  bus_nxm #(.NUM_M(2), .NUM_S(5), .AW(16), .DW(32), .SEL_LSB(8), .WIN_BITS(6), .MAX_HOLD(4))
    dut_c (.clk(clk), .reset(reset), .mst(ic), .slv(ic));

  localparam logic [5*32-1:0] SLV_DATA =
    {32'h4444_0004, 32'h3333_0003, 32'h0005_0000, 32'h1111_0001, 32'hCAFE_0000};

  task automatic clear_inputs();
    ia.m_req = '0; ia.m_wr = '0; ia.m_addr = '0; ia.m_dout = '0; ia.s_dout = SLV_DATA;
    ib.m_req = '0; ib.m_wr = '0; ib.m_addr = '0; ib.m_dout = '0; ib.s_dout = SLV_DATA;
    ic.m_req = '0; ic.m_wr = '0; ic.m_addr = '0; ic.m_dout = '0; ic.s_dout = SLV_DATA;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    clear_inputs();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    step();
    total++; if (ia.m_grant !== 2'b00) begin bad++; $display("FAIL reset_grant: got %b want 00", ia.m_grant); end
    total++; if (ia.s_sel !== 5'b0) begin bad++; $display("FAIL reset_sel: got %b want 00000", ia.s_sel); end
    total++; if (ia.m_din !== 32'h0) begin bad++; $display("FAIL reset_din: got %h want 0", ia.m_din); end
    total++; if (ia.dec_err !== 1'b0) begin bad++; $display("FAIL reset_decerr: got %b want 0", ia.dec_err); end
    total++; if (ia.s_addr !== 16'h0 || ia.s_wr !== 1'b0 || ia.s_din !== 32'h0)
      begin bad++; $display("FAIL reset_bus: got addr=%h wr=%b din=%h want 0", ia.s_addr, ia.s_wr, ia.s_din); end
    reset = 1'b0;
    step();
    total++; if (ia.m_grant !== 2'b01) begin bad++; $display("FAIL reset_first_grant: got %b want 01", ia.m_grant); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ia.m_req = 2'b01;
    ia.m_addr = {16'h0000, 16'h0200};
    step();
    total++; if (ia.m_grant !== 2'b01) begin bad++; $display("FAIL mid_pre_grant: got %b want 01", ia.m_grant); end
    reset = 1'b1;
    step();
    total++; if (ia.m_grant !== 2'b00) begin bad++; $display("FAIL mid_grant: got %b want 00", ia.m_grant); end
    total++; if (ia.m_din !== 32'h0) begin bad++; $display("FAIL mid_din: got %h want 0", ia.m_din); end
    total++; if (ia.s_sel !== 5'b0) begin bad++; $display("FAIL mid_sel: got %b want 00000", ia.s_sel); end
    reset = 1'b0;
  endtask

  task automatic test_read();
    do_reset();
    ia.m_req = 2'b01;
    ia.m_wr = 2'b00;
    ia.m_addr = {16'h0000, 16'h0200};
    step();
    total++; if (ia.m_grant !== 2'b01) begin bad++; $display("FAIL rd_grant: got %b want 01", ia.m_grant); end
    total++; if (ia.s_sel !== 5'b00100) begin bad++; $display("FAIL rd_sel: got %b want 00100", ia.s_sel); end
    total++; if (ia.s_addr !== 16'h0200) begin bad++; $display("FAIL rd_addr: got %h want 0200", ia.s_addr); end
    total++; if (ia.m_din !== 32'h0) begin bad++; $display("FAIL rd_din_early: got %h want 0", ia.m_din); end
    step();
    total++; if (ia.m_din !== 32'h0005_0000) begin bad++; $display("FAIL rd_din: got %h want 00050000", ia.m_din); end
    ia.m_req = 2'b00;
    step();
    step();
    total++; if (ia.m_din !== 32'h0) begin bad++; $display("FAIL rd_din_idle: got %h want 0", ia.m_din); end
    total++; if (ia.m_grant !== 2'b00) begin bad++; $display("FAIL rd_grant_idle: got %b want 00", ia.m_grant); end
  endtask

  task automatic test_write();
    do_reset();
    ia.m_req = 2'b10;
    ia.m_wr = 2'b10;
    ia.m_addr = {16'h0300, 16'h0000};
    ia.m_dout = {32'h8000_0000, 32'h0};
    step();
    total++; if (ia.m_grant !== 2'b10) begin bad++; $display("FAIL wr_grant: got %b want 10", ia.m_grant); end
    total++; if (ia.s_sel !== 5'b01000) begin bad++; $display("FAIL wr_sel: got %b want 01000", ia.s_sel); end
    total++; if (ia.s_wr !== 1'b1) begin bad++; $display("FAIL wr_strobe: got %b want 1", ia.s_wr); end
    total++; if (ia.s_din !== 32'h8000_0000) begin bad++; $display("FAIL wr_din: got %h want 80000000", ia.s_din); end
    total++; if (ia.s_addr !== 16'h0300) begin bad++; $display("FAIL wr_addr: got %h want 0300", ia.s_addr); end
    step();
    total++; if (ia.m_din !== 32'h0) begin bad++; $display("FAIL wr_mdin: got %h want 0", ia.m_din); end
    total++; if (ia.dec_err !== 1'b0) begin bad++; $display("FAIL wr_decerr: got %b want 0", ia.dec_err); end
  endtask

  task automatic test_decode_err();
    do_reset();
    ia.m_req = 2'b01;
    ia.m_addr = {16'h0000, 16'h0040};
    step();
    total++; if (ia.s_sel !== 5'b0) begin bad++; $display("FAIL de_sel_gap: got %b want 00000", ia.s_sel); end
    total++; if (ia.dec_err !== 1'b0) begin bad++; $display("FAIL de_err_early: got %b want 0", ia.dec_err); end
    step();
    total++; if (ia.dec_err !== 1'b1) begin bad++; $display("FAIL de_err_gap: got %b want 1", ia.dec_err); end
    total++; if (ia.m_din !== 32'h0) begin bad++; $display("FAIL de_din_gap: got %h want 0", ia.m_din); end
    ia.m_addr = {16'h0000, 16'h0500};
    #1;
    total++; if (ia.s_sel !== 5'b0) begin bad++; $display("FAIL de_sel_idx: got %b want 00000", ia.s_sel); end
    step();
    total++; if (ia.dec_err !== 1'b1) begin bad++; $display("FAIL de_err_idx: got %b want 1", ia.dec_err); end
    total++; if (ia.m_din !== 32'h0) begin bad++; $display("FAIL de_din_idx: got %h want 0", ia.m_din); end
    ia.m_addr = {16'h0000, 16'h043F};
    #1;
    total++; if (ia.s_sel !== 5'b10000) begin bad++; $display("FAIL de_sel_edge: got %b want 10000", ia.s_sel); end
    step();
    total++; if (ia.dec_err !== 1'b0) begin bad++; $display("FAIL de_err_edge: got %b want 0", ia.dec_err); end
    total++; if (ia.m_din !== 32'h4444_0004) begin bad++; $display("FAIL de_din_edge: got %h want 44440004", ia.m_din); end
    ia.m_req = 2'b00;
  endtask

  task automatic test_no_limit();
    do_reset();
    ia.m_req = 2'b11;
    ia.m_addr = {16'h0100, 16'h0200};
    step();
    total++; if (ia.m_grant !== 2'b01) begin bad++; $display("FAIL nl_first: got %b want 01", ia.m_grant); end
    ia.m_req = 2'b10;
    step();
    total++; if (ia.m_grant !== 2'b10) begin bad++; $display("FAIL nl_handover: got %b want 10", ia.m_grant); end
    total++; if (ia.s_addr !== 16'h0100) begin bad++; $display("FAIL nl_addr: got %h want 0100", ia.s_addr); end
    ia.m_req = 2'b11;
    for (int i = 0; i < 8; i++) begin
      step();
      total++; if (ia.m_grant !== 2'b10) begin bad++; $display("FAIL nl_hold[%0d]: got %b want 10", i, ia.m_grant); end
    end
    ia.m_req = 2'b00;
  endtask

  task automatic test_round_robin();
    logic [2:0] req_seq [5];
    logic [2:0] exp_seq [5];
    req_seq = '{3'b110, 3'b101, 3'b001, 3'b000, 3'b000};
    exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b000};
    do_reset();
    ib.m_req = 3'b111;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (ib.m_grant !== exp_seq[i]) begin bad++; $display("FAIL rr_grant[%0d]: got %b want %b", i, ib.m_grant, exp_seq[i]); end
      ib.m_req = req_seq[i];
    end
  endtask

  task automatic test_preempt();
    logic [1:0] exp;
    do_reset();
    ic.m_req = 2'b11;
    for (int i = 0; i < 12; i++) begin
      step();
      exp = (((i / 4) % 2) == 0) ? 2'b01 : 2'b10;
      total++; if (ic.m_grant !== exp) begin bad++; $display("FAIL pre_grant[%0d]: got %b want %b", i, ic.m_grant, exp); end
    end
    ic.m_req = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    clear_inputs();
    ia.m_req = 2'b11;
    test_reset();
    test_reset_mid();
    test_read();
    test_write();
    test_decode_err();
    test_no_limit();
    test_round_robin();
    test_preempt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bus_nxm.md
Name: bus_nxm

Overview:
- Parametrised successor to the two-master / five-slave shared bus.
- Arbitrates NUM_M masters onto one shared slave-side bus with round-robin fairness and optional grant-hold limit.
- Decodes the granted address onto NUM_S slave windows, flags unmapped accesses, and returns read data with one-cycle latency.
- Sits between masters (DMAC, CPU-side ports) and memory-mapped slaves (ALU register file, memories).

Parameters:
NUM_M, 2, number of masters (2..8)
NUM_S, 5, number of slaves (1..8)
AW, 16, address width
DW, 32, data width
SEL_LSB, 8, lowest address bit of slave index field; slave i base = i << SEL_LSB
WIN_BITS, 6, each slave window spans 2^WIN_BITS words from its base (requires WIN_BITS <= SEL_LSB)
MAX_HOLD, 0, max consecutive grant cycles while others wait; 0 = unlimited

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
m_req  in  NUM_M  per-master bus request
m_wr  in  NUM_M  per-master write strobe (1 = write, 0 = read)
m_addr  in  NUM_M*AW  packed master addresses, master k at [k*AW +: AW]
m_dout  in  NUM_M*DW  packed master write data
s_dout  in  NUM_S*DW  packed slave read data
m_grant  out  NUM_M  one-hot (or zero) registered grant
m_din  out  DW  read data returned to masters
s_sel  out  NUM_S  one-hot slave select
s_addr  out  AW  shared slave address
s_wr  out  1  shared write strobe
s_din  out  DW  shared slave write data
dec_err  out  1  one-cycle pulse: previous granted access hit no slave

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: m_grant=0, rr_ptr=0, hold_cnt=0, rd_idx=0, rd_vld=0, dec_err=0.
  - Derived outputs during reset: s_sel=0, s_wr=0, s_addr=0, s_din=0, m_din=0.
- Arbiter states: IDLE (m_grant==0) and OWN(k). Evaluated every rising edge:
  - IDLE, any m_req: grant the first requester at or after rr_ptr (circular order). Grant is visible the next cycle.
  - OWN(k), m_req[k]=1, and either no other request or hold limit not reached: keep k; hold_cnt++ (saturating).
  - OWN(k), m_req[k]=0: hand over directly to the next requester after k in circular order, else go IDLE. No dead cycle.
  - OWN(k), MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, another m_req set: preempt to the next requester after k.
  - On every new grant to k: rr_ptr=k+1 mod NUM_M, hold_cnt=0.
- Slave side, combinational from the owner's signals:
  - s_addr, s_wr, s_din are the owner's values; all 0 in IDLE.
- Decode:
  - idx = addr[SEL_LSB +: clog2(NUM_S)].
  - Hit iff idx<NUM_S, addr[SEL_LSB-1:WIN_BITS]==0, and bits above the idx field are 0.
  - s_sel[idx]=1 on hit while owned; otherwise s_sel=0.
- Read return:
  - Each edge: rd_vld <= owned & ~s_wr & hit; rd_idx <= idx.
  - m_din = rd_vld ? s_dout[rd_idx] : 0. Data is valid the cycle after the address, and all masters see the same m_din.
- dec_err <= owned & ~hit. Writes to unmapped addresses are dropped (no s_sel).
- Reset asserted mid-grant: grant drops at that edge; pending read return is discarded (rd_vld=0).

Decomposition:
- Package bus_pkg holds:
  - default AW/DW constants
  - clog2 function
  - addr_decode function (addr -> hit, idx)
  - next_rr function (req vector, start index -> winner)
- One sub-module, bus_rr_arbiter: m_req in, m_grant/owner index out, holds rr_ptr and hold_cnt.
- bus_nxm instantiates the arbiter and holds the decode and read-return muxing.

Test Plan:
- Reset: reset=1 for 1 cycle with m_req=2'b11 -> m_grant=0, s_sel=0, m_din=0, dec_err=0; after release, m_grant=2'b01 next cycle.
- Read: m0 req, wr=0, addr=0x0200, s_dout[2]=0x0005_0000 -> s_sel=5'b00100 in the granted cycle; m_din=0x0005_0000 one cycle later.
- Write: m1 req, wr=1, addr=0x0300, dout=0x8000_0000 -> s_sel=5'b01000, s_wr=1, s_din=0x8000_0000, s_addr=0x0300; m_din=0.
- Round-robin with NUM_M=3, all requesting and each dropping after 1 access -> grant order 0,1,2,0 with no idle cycle between owners.
- Preemption with MAX_HOLD=4: m0 and m1 held high -> m0 owns 4 cycles, then m1 owns 4, alternating.
- Decode error: m0 reads 0x0040, then 0x0500 (NUM_S=5) -> s_sel=0 both; dec_err pulses the cycle after each; m_din=0.
